// File: rtl/get1num_pkg.sv
// Shared constants and width helper for the population-count pipeline.
package get1num_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int RET_W_DEF  = 32;

    // Bits needed to hold a count in the range 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count built as a recursive balanced pairwise adder tree.
module popcount_tree
    import get1num_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]          vec,
    output logic [cnt_w(DATA_W)-1:0]   cnt
);

    localparam int CW = cnt_w(DATA_W);

    generate
        if (DATA_W == 1) begin : g_leaf
            assign cnt = vec;
        end else begin : g_node
            // Upper half takes the odd bit so both subtrees stay within one level of each other.
            localparam int LO_W = DATA_W / 2;
            localparam int HI_W = DATA_W - LO_W;

            logic [cnt_w(LO_W)-1:0] cnt_lo;
            logic [cnt_w(HI_W)-1:0] cnt_hi;

            popcount_tree #(.DATA_W(LO_W)) u_lo (
                .vec (vec[LO_W-1:0]),
                .cnt (cnt_lo)
            );

            popcount_tree #(.DATA_W(HI_W)) u_hi (
                .vec (vec[DATA_W-1:LO_W]),
                .cnt (cnt_hi)
            );

            assign cnt = CW'(cnt_lo) + CW'(cnt_hi);
        end
    endgenerate

endmodule

// File: rtl/get1num_add_pipe.sv
// Two-stage registered popcount: stage 1 captures the word, stage 2 registers its
// bit count into ret, which holds its last value between valid words.
module get1num_add_pipe
    import get1num_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RET_W  = RET_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [RET_W-1:0]  ret
);

    localparam int CW = cnt_w(DATA_W);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [RET_W-1:0]  ret_q, ret_d;
    logic              o_valid_q, o_valid_d;
    logic [CW-1:0]     cnt;

    popcount_tree #(.DATA_W(DATA_W)) u_tree (
        .vec (data_q),
        .cnt (cnt)
    );

    always_comb begin
        data_d    = i_data;
        valid_d   = i_valid;
        o_valid_d = valid_q;
        ret_d     = ret_q;
        // Data captured on an invalid cycle never reaches ret.
        if (valid_q) begin
            ret_d = RET_W'(cnt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            ret_q     <= '0;
            o_valid_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            ret_q     <= ret_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign o_valid = o_valid_q;
    assign ret     = ret_q;

endmodule

// File: tb/tb_get1num_add_pipe.sv
// Scoreboard bench for three widths (8, 16, 1) of get1num_add_pipe sharing clock and reset.
module tb_get1num_add_pipe;

    typedef struct {
        int due;
        int exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [7:0]  d8 = '0;
    logic [15:0] d16 = '0;
    logic [0:0]  d1 = '0;

    logic        ov8, ov16, ov1;
    logic [31:0] r8, r16, r1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[3][$];
    int   last_r[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    get1num_add_pipe #(.DATA_W(8), .RET_W(32)) dut8 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(d8), .o_valid(ov8), .ret(r8)
    );
    get1num_add_pipe #(.DATA_W(16), .RET_W(32)) dut16 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(d16), .o_valid(ov16), .ret(r16)
    );
    get1num_add_pipe #(.DATA_W(1), .RET_W(32)) dut1 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(d1), .o_valid(ov1), .ret(r1)
    );

    task automatic chk(input int k, input logic ov, input logic [31:0] r);
        exp_t e;
        if (rst) begin
            checks++;
            if (ov !== 1'b0 || r !== 32'd0) begin
                errors++;
                $display("FAIL reset_out[%0d] o_valid=%b ret=%0d want 0/0 t=%0t", k, ov, r, $time);
            end
            last_r[k] = 0;
        end else if (ov === 1'b1) begin
            checks++;
            if (q[k].size() == 0) begin
                errors++;
                $display("FAIL unexpected_result[%0d] ret=%0d want no o_valid cyc=%0d", k, r, cyc);
            end else begin
                e = q[k].pop_front();
                if (r !== 32'(e.exp) || cyc != e.due) begin
                    errors++;
                    $display("FAIL result[%0d] ret=%0d cyc=%0d want ret=%0d cyc=%0d", k, r, cyc, e.exp, e.due);
                end
                last_r[k] = e.exp;
            end
        end else begin
            checks++;
            if (ov !== 1'b0 || r !== 32'(last_r[k])) begin
                errors++;
                $display("FAIL hold[%0d] o_valid=%b ret=%0d want 0/%0d cyc=%0d", k, ov, r, last_r[k], cyc);
            end
            if (q[k].size() > 0 && q[k][0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_result[%0d] o_valid=0 want ret=%0d at cyc=%0d", k, q[k][0].exp, q[k][0].due);
                void'(q[k].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        chk(0, ov8, r8);
        chk(1, ov16, r16);
        chk(2, ov1, r1);
    end

    task automatic step(input logic v, input logic [7:0] a8, input logic [15:0] a16, input logic a1);
        @(posedge clk);
        #1;
        i_valid = v;
        d8      = a8;
        d16     = a16;
        d1      = a1;
        if (v && !rst) begin
            q[0].push_back('{due: cyc + 2, exp: $countones(a8)});
            q[1].push_back('{due: cyc + 2, exp: $countones(a16)});
            q[2].push_back('{due: cyc + 2, exp: $countones(a1)});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 8'($urandom), 16'($urandom), 1'($urandom));
        end
    endtask

    task automatic imm_chk();
        checks++;
        if (ov8 !== 1'b0 || ov16 !== 1'b0 || ov1 !== 1'b0 ||
            r8 !== 32'd0 || r16 !== 32'd0 || r1 !== 32'd0) begin
            errors++;
            $display("FAIL async_reset o_valid=%b%b%b ret=%0d/%0d/%0d want 0 and 0", ov8, ov16, ov1, r8, r16, r1);
        end
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        i_valid = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) last_r[k] = 0;

        // Reset held with live valid traffic
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 16'($urandom), 1'($urandom));
        release_rst();
        idle(2);

        // Basic count, then hold
        step(1'b1, 8'b0111_0001, 16'h1234, 1'b1);
        idle(4);

        // Extremes back-to-back
        step(1'b1, 8'h00, 16'h0000, 1'b0);
        step(1'b1, 8'hFF, 16'hFFFF, 1'b1);
        step(1'b1, 8'h01, 16'h0001, 1'b1);
        step(1'b1, 8'h80, 16'h8000, 1'b0);
        idle(3);

        // Gapped valid
        step(1'b1, 8'hAA, 16'hAAAA, 1'b1);
        step(1'b0, 8'hFF, 16'hFFFF, 1'b1);
        step(1'b1, 8'h0F, 16'h00FF, 1'b0);
        idle(3);

        // Asynchronous reset with two words in flight
        step(1'b1, 8'hF0, 16'hF0F0, 1'b1);
        step(1'b1, 8'h3C, 16'h7FFF, 1'b1);
        @(posedge clk);
        #2;
        rst     = 1'b1;
        i_valid = 1'b0;
        #1;
        imm_chk();
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            last_r[k] = 0;
        end
        idle(2);
        release_rst();
        idle(4);

        // Exhaustive 8-bit stream
        for (int v = 0; v < 256; v++) begin
            step(1'b1, 8'(v), 16'($urandom), 1'(v));
        end
        idle(3);

        // Random traffic with gaps
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom), 16'($urandom), 1'($urandom));
        end
        idle(5);

        for (int k = 0; k < 3; k++) begin
            checks++;
            if (q[k].size() != 0) begin
                errors++;
                $display("FAIL drain[%0d] pending=%0d want 0", k, q[k].size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/get1num_add_pipe.md
Name: get1num_add_pipe

Overview:
- Registered population-count block: counts the number of '1' bits in an input word and returns the count zero-extended to a wide result bus.
- Sits on a single clock domain as a utility/arithmetic leaf; results feed downstream status/statistics logic.
- Pipelined with a valid qualifier, so one new word may be accepted every cycle.

Parameters:
- DATA_W, 8, width of i_data in bits; legal range 1..64.
- RET_W, 32, width of ret; must be >= $clog2(DATA_W+1); upper bits are zero.

Ports:
- clk, input, 1, single system clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- i_valid, input, 1, qualifies i_data for the current cycle.
- i_data, input, DATA_W, word whose set bits are counted.
- o_valid, output, 1, ret carries a new result this cycle.
- ret, output, RET_W, number of '1' bits in the accepted word, zero-extended.

Behaviour:
- Reset:
  - One clock, clk; reset is asynchronous and active-high (port rst).
  - While rst is high: o_valid=0, ret=0, and all internal pipeline registers cleared.
  - Reset assertion takes effect immediately, with no clock needed.
  - Deassertion is sampled on the next clk rising edge.
- Stage 1 (edge N): register i_data and i_valid unconditionally.
- Stage 2 (edge N+1): compute the popcount of the stage-1 data with a balanced adder tree.
  - Register the count into ret and the stage-1 valid into o_valid.
- Latency:
  - Exactly 2 clk edges from i_valid/i_data sampled to o_valid/ret.
  - Throughput is 1 word per cycle; no backpressure and no ready signal.
- Hold rule:
  - When the stage-1 valid is 0, ret holds its previous value and o_valid=0.
  - ret updates only for valid words.
- Arithmetic:
  - Count range is 0..DATA_W.
  - Adder-tree widths grow by one bit per level.
  - Final sum is zero-extended to RET_W; no overflow is possible.
- Boundaries:
  - All-zeros input gives 0; all-ones input gives DATA_W.
  - A single set bit at LSB or MSB gives 1.
  - Back-to-back valid words produce back-to-back results in order.
- Reset mid-operation: in-flight words are discarded and no o_valid is produced for them.
- X-handling: i_data is don't-care when i_valid=0 and must not affect ret.

Decomposition:
- Shared package get1num_pkg:
  - Default constants DATA_W_DEF=8 and RET_W_DEF=32.
  - Function cnt_w(n) returning $clog2(n+1).
- Sub-module popcount_tree (purely combinational):
  - Parameter DATA_W; input vec[DATA_W-1:0]; output cnt[cnt_w(DATA_W)-1:0].
  - Recursive or generate-based pairwise adder tree.
- The top module instantiates popcount_tree between its two register stages.

Test Plan:
- Reset check: hold rst=1 for 5 cycles with random i_data and i_valid=1 -> o_valid=0 and ret=0 throughout.
  - Release rst; first result appears exactly 2 edges after the first valid sample.
- Basic count: i_data=8'b0111_0001, i_valid=1 for one cycle -> o_valid=1 for one cycle and ret=32'd4, two edges later.
  - ret stays 4 afterwards while o_valid=0.
- Extremes: sequence 8'h00, 8'hFF, 8'h01, 8'h80 back-to-back with i_valid=1 -> ret=0, 8, 1, 1 on consecutive cycles.
  - o_valid stays high for 4 cycles.
- Gapped valid: words 8'hAA (valid), 8'hFF (invalid), 8'h0F (valid) -> results 4, then hold 4 with o_valid=0, then 4.
  - The 8'hFF word is ignored.
- Reset mid-stream: assert rst asynchronously between clock edges while two words are in flight -> ret=0 and o_valid=0 immediately.
  - No result emerges for those words after release.
- Exhaustive/random: all 256 values of i_data streamed back-to-back -> each ret equals the reference popcount, in order, 2-cycle latency.
  - Repeat with DATA_W=16 and DATA_W=1 (ret=0/1).
